// File: rtl/icosoc_mod_qspi_slave_fifo.sv
`default_nettype none
// ============================================================================
// Module  : icosoc_mod_qspi_slave_fifo
// Brief   : QSPI slave (1/2/4 lanes) with RX/TX byte FIFOs behind a register bus
// Revision: 1.0
// ============================================================================
module icosoc_mod_qspi_slave_fifo #(
  parameter int DWIDTH     = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  ctrl_wr,
  input  logic        ctrl_rd,
  input  logic [15:0] ctrl_addr,
  input  logic [31:0] ctrl_wdat,
  output logic [31:0] ctrl_rdat,
  output logic        ctrl_done,
  input  logic        qck_i,
  input  logic        qss_i,
  input  logic [3:0]  qd_i,
  output logic [3:0]  qd_o,
  output logic [3:0]  qd_oe
);

  localparam int         AW         = $clog2(FIFO_DEPTH);
  localparam logic [2:0] LAST_CHUNK = 3'(8 / DWIDTH - 1);
  localparam logic [8:0] DEPTH      = 9'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RX   = 2'd1;
  localparam logic [1:0] S_TX   = 2'd2;

  logic [1:0] qck_sync, qss_sync;
  logic [3:0] qd_meta, qd_sync;
  logic       qck_prev, qss_prev;
  logic [1:0] state, state_next;
  logic [7:0] rx_shift, tx_shift, rx_byte, tx_head;
  logic [2:0] rx_cnt, tx_cnt;
  logic [7:0] rx_mem [FIFO_DEPTH];
  logic [7:0] tx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wr, rx_rd, tx_wr, tx_rd;
  logic [8:0] rx_count, tx_count;
  logic       rx_ovf, tx_ovf, tx_und, dir, auto_dir;
  logic [3:0] tx_lanes, lane_mask;
  logic [31:0] rdat_next;
  logic [2:0] flag_clr;

  // Synchronisers reset low so a select held through reset never looks like a fall
  always_ff @(posedge clk) begin
    if (reset) begin
      qck_sync <= 2'b00;
      qss_sync <= 2'b00;
      qd_meta  <= 4'h0;
      qd_sync  <= 4'h0;
      qck_prev <= 1'b0;
      qss_prev <= 1'b0;
    end else begin
      qck_sync <= {qck_sync[0], qck_i};
      qss_sync <= {qss_sync[0], qss_i};
      qd_meta  <= qd_i;
      qd_sync  <= qd_meta;
      qck_prev <= qck_sync[1];
      qss_prev <= qss_sync[1];
    end
  end

  logic sample_ev, shift_ev, qss_fall, qss_rise, leaving;
  assign sample_ev = qck_sync[1] & ~qck_prev & ~qss_sync[1];
  assign shift_ev  = ~qck_sync[1] & qck_prev & ~qss_sync[1];
  assign qss_fall  = qss_prev & ~qss_sync[1];
  assign qss_rise  = ~qss_prev & qss_sync[1];
  assign leaving   = (state != S_IDLE) & qss_rise;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (qss_fall) state_next = dir ? S_TX : S_RX;
      S_RX,
      S_TX:    if (qss_rise) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  generate
    if (DWIDTH == 1) begin : g_lane1
      assign tx_lanes  = {2'b00, tx_shift[7], 1'b0};
      assign lane_mask = 4'b0010;
    end else if (DWIDTH == 2) begin : g_lane2
      assign tx_lanes  = {2'b00, tx_shift[7:6]};
      assign lane_mask = 4'b0011;
    end else begin : g_lane4
      assign tx_lanes  = tx_shift[7:4];
      assign lane_mask = 4'b1111;
    end
  endgenerate

  always_comb begin
    qd_o  = 4'b0000;
    qd_oe = 4'b0000;
    if (state == S_TX) begin
      qd_o  = tx_lanes;
      qd_oe = lane_mask;
    end
  end

  logic acc, wr_acc, rd_acc, a_data, a_stat, a_ctrl;
  logic rx_push, rx_pop, tx_push, tx_pop, tx_load, rx_done, flush;
  logic rx_empty, rx_full, tx_empty, tx_full;
  assign acc     = (|ctrl_wr | ctrl_rd) & ~ctrl_done;
  assign wr_acc  = acc & (|ctrl_wr);
  assign rd_acc  = acc & ctrl_rd;
  assign a_data  = (ctrl_addr == 16'h0000);
  assign a_stat  = (ctrl_addr == 16'h0004);
  assign a_ctrl  = (ctrl_addr == 16'h0008);
  assign rx_empty = (rx_count == 9'd0);
  assign tx_empty = (tx_count == 9'd0);
  assign rx_full  = (rx_count == DEPTH);
  assign tx_full  = (tx_count == DEPTH);
  assign rx_byte  = {rx_shift[7-DWIDTH:0], qd_sync[DWIDTH-1:0]};
  assign rx_done  = (state == S_RX) & sample_ev & (rx_cnt == LAST_CHUNK);
  assign rx_push  = rx_done & ~rx_full;
  assign rx_pop   = rd_acc & a_data & ~rx_empty;
  assign tx_push  = wr_acc & a_data & ~tx_full;
  assign tx_load  = ((state == S_IDLE) & qss_fall & dir) |
                    ((state == S_TX) & shift_ev & (tx_cnt == LAST_CHUNK));
  assign tx_pop   = tx_load & ~tx_empty;
  assign tx_head  = tx_empty ? 8'h00 : tx_mem[tx_rd];
  assign flush    = wr_acc & a_ctrl & ctrl_wr[0] & ctrl_wdat[2];
  assign flag_clr = (wr_acc & a_stat & ctrl_wr[0]) ? ctrl_wdat[2:0] : 3'b000;

  always_comb begin
    rdat_next = 32'h0;
    if (a_data)      rdat_next = {23'h0, ~rx_empty, rx_empty ? 8'h00 : rx_mem[rx_rd]};
    else if (a_stat) rdat_next = {rx_count, tx_count, 10'h0, state != S_IDLE, rx_ovf, tx_ovf, tx_und};
    else if (a_ctrl) rdat_next = {29'h0, 1'b0, auto_dir, dir};
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr] <= rx_byte;
    if (tx_push) tx_mem[tx_wr] <= ctrl_wdat[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_shift <= 8'h00;  rx_cnt <= 3'd0;
      tx_shift <= 8'h00;  tx_cnt <= 3'd0;
      rx_wr <= '0;  rx_rd <= '0;  rx_count <= 9'd0;
      tx_wr <= '0;  tx_rd <= '0;  tx_count <= 9'd0;
      rx_ovf <= 1'b0;  tx_ovf <= 1'b0;  tx_und <= 1'b0;
      dir <= 1'b0;  auto_dir <= 1'b0;
      ctrl_done <= 1'b0;  ctrl_rdat <= 32'h0;
    end else begin
      ctrl_done <= acc;
      ctrl_rdat <= rd_acc ? rdat_next : 32'h0;

      if (state != S_RX) rx_cnt <= 3'd0;
      else if (sample_ev) begin
        rx_shift <= rx_byte;
        rx_cnt   <= (rx_cnt == LAST_CHUNK) ? 3'd0 : rx_cnt + 3'd1;
      end

      if (tx_load) begin
        tx_shift <= tx_head;
        tx_cnt   <= 3'd0;
      end else if ((state == S_TX) & shift_ev) begin
        tx_shift <= {tx_shift[7-DWIDTH:0], {DWIDTH{1'b0}}};
        tx_cnt   <= tx_cnt + 3'd1;
      end

      // Flush overrides any push or pop landing in the same cycle
      if (flush) begin
        rx_wr <= '0;  rx_rd <= '0;  rx_count <= 9'd0;
        tx_wr <= '0;  tx_rd <= '0;  tx_count <= 9'd0;
      end else begin
        if (rx_push) rx_wr <= rx_wr + PTR_ONE;
        if (rx_pop)  rx_rd <= rx_rd + PTR_ONE;
        if (rx_push & ~rx_pop)      rx_count <= rx_count + 9'd1;
        else if (~rx_push & rx_pop) rx_count <= rx_count - 9'd1;
        if (tx_push) tx_wr <= tx_wr + PTR_ONE;
        if (tx_pop)  tx_rd <= tx_rd + PTR_ONE;
        if (tx_push & ~tx_pop)      tx_count <= tx_count + 9'd1;
        else if (~tx_push & tx_pop) tx_count <= tx_count - 9'd1;
      end

      rx_ovf <= (rx_ovf & ~flag_clr[2]) | (rx_done & rx_full);
      tx_ovf <= (tx_ovf & ~flag_clr[1]) | (wr_acc & a_data & tx_full);
      tx_und <= (tx_und & ~flag_clr[0]) | (tx_load & tx_empty);

      if (wr_acc & a_ctrl & ctrl_wr[0]) begin
        dir      <= ctrl_wdat[0];
        auto_dir <= ctrl_wdat[1];
      end
      if (leaving & auto_dir) dir <= ~dir;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{ctrl_wdat[31:8], qd_sync};

endmodule
`default_nettype wire
